cache_mem_arbiter: RTL
======================

Name: cache_mem_arbiter

Overview:
Shares the single external memory port between the instruction-cache refill path and the data-cache refill/write-back path.
Grants one requester at a time and sequences a LINE_WORDS-beat burst as single-word req/ack handshakes.
Returns per-beat data to the granted requester.
Drives the waiting signals that freeze the F and M pipeline control registers until that requester's burst completes.

Parameters:
ADDR_W, 32, byte address width
DATA_W, 32, word width (4 bytes per beat)
LINE_WORDS, 4, beats per burst (power of two, >=2)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
ic_req  in  1  I-cache refill request, held until ic_done
ic_addr  in  ADDR_W  I-cache miss address (any byte in line)
ic_rvalid  out  1  I-cache beat valid
ic_rdata  out  DATA_W  I-cache beat data
ic_done  out  1  one-cycle pulse, last I-cache beat
ic_waiting  out  1  F-stage stall
dc_req  in  1  D-cache request, held until dc_done
dc_we  in  1  1 = write-back burst, 0 = refill
dc_addr  in  ADDR_W  D-cache line address (any byte in line)
dc_wdata  in  DATA_W  write-back word for current beat
dc_beat  out  clog2(LINE_WORDS)  current beat index, used by D-cache to select dc_wdata
dc_rvalid  out  1  D-cache read beat valid
dc_rdata  out  DATA_W  D-cache read beat data
dc_done  out  1  one-cycle pulse, last D-cache beat
dc_waiting  out  1  M-stage stall
mem_req  out  1  memory request
mem_we  out  1  memory write
mem_addr  out  ADDR_W  word address of beat
mem_wdata  out  DATA_W  write data
mem_ack  in  1  memory accepts beat; read data valid same cycle
mem_rdata  in  DATA_W  read data

Behaviour:
- Clock and reset: already decided, one clock (clk); reset (rst) is synchronous and active-high.
- Reset values: all outputs 0, state IDLE, beat counter 0, last_grant = IC (first tie goes to DC).
- FSM states: IDLE, IC_XFER, DC_XFER.
- IDLE:
  - Only one request asserted: go to its XFER state next cycle.
  - Both asserted: grant the one not equal to last_grant (round-robin).
  - On grant: latch line base = addr with low clog2(LINE_WORDS)+2 bits cleared; latch dc_we; clear beat counter.
- XFER:
  - mem_req = 1.
  - mem_addr = base + 4*beat.
  - mem_we = latched dc_we in DC_XFER, 0 in IC_XFER.
  - mem_wdata = dc_wdata combinationally.
  - dc_beat = beat while in DC_XFER; 0 otherwise.
- Each cycle mem_ack=1 is one beat:
  - Reads: rvalid=1 and rdata=mem_rdata for the granted side, same cycle (combinational pass-through); rdata = 0 when not valid.
  - Beat counter increments.
  - Beat LINE_WORDS-1 acked: done pulses the same cycle, last_grant is updated, state returns to IDLE.
  - Minimum burst: LINE_WORDS cycles plus 1 IDLE cycle before the next grant.
- mem_req never drops mid-burst. mem_addr and mem_we stay stable while mem_req=1 and mem_ack=0.
- Waiting signals:
  - ic_waiting = ic_req & ~ic_done.
  - dc_waiting = dc_req & ~dc_done.
  - Both are combinational and high from the request cycle, including arbitration-loss cycles.
- Requests must be held until done:
  - Deassertion mid-burst is ignored; the burst completes, but done/rvalid still pulse.
  - A request that deasserts in IDLE before its grant is dropped.
- Request still asserted in the cycle after done: treated as a new request (requester must drop it on done).
- Reset mid-burst: immediate return to IDLE, mem_req=0 next cycle, no done pulse.
- Beat counter wraps naturally at LINE_WORDS; it is cleared on every grant.

Optional Feature:
ARB_STATS_EN
- Defined:
  - Adds 32-bit outputs stat_ic_bursts, stat_dc_bursts, stat_conflicts and stat_mem_wait.
  - The burst counters increment on done; stat_conflicts increments on IDLE cycles with both requests; stat_mem_wait increments on mem_req & ~mem_ack.
  - All saturate at 2^32-1 and reset to 0.
- Undefined: these ports and counters do not exist.

Decomposition:
- Shared package cache_pkg:
  - arb_state_t enum {IDLE, IC_XFER, DC_XFER}.
  - Requester id constants GNT_IC=0, GNT_DC=1.
  - LINE_WORDS default and a BYTE_OFF_W localparam function.
- One sub-module: arb_rr2, the 2-way round-robin picker (inputs: two reqs, last_grant; output: winner id, valid).

Test Plan:
- IC refill alone: ic_req, ic_addr=0x0000_104C, mem_ack always 1.
  - mem_addr 0x1040, 0x1044, 0x1048, 0x104C on consecutive cycles.
  - ic_rvalid x4; ic_done on the 4th beat; ic_waiting falls the same cycle.
- DC write-back with stalls: dc_we=1, dc_addr=0x2008, mem_ack low 2 cycles per beat.
  - mem_addr/mem_we held stable during stalls.
  - dc_beat 0..3 tracks beats; mem_wdata follows dc_wdata.
  - Burst takes 12 cycles; dc_done once.
- Simultaneous ic_req and dc_req from reset:
  - DC granted first; IC granted after DC done plus 1 IDLE cycle.
  - ic_waiting high throughout.
- Back-to-back contention: both re-request immediately after their done.
  - Grants alternate DC, IC, DC, IC; stat_conflicts counts each contended IDLE cycle (ARB_STATS_EN).
- Reset asserted on beat 2 of an IC refill:
  - mem_req=0 next cycle, no ic_done, all outputs 0.
  - A fresh request afterwards starts at beat 0.
- dc_req deasserted after beat 1: the burst still completes 4 beats and dc_done pulses.

Source files
------------

// File: rtl/cache_pkg.sv
`default_nettype none
// ============================================================================
// Module  : cache_pkg
// Purpose : Shared types and constants for the cache/memory arbiter.
//           - arb_state_t : arbiter FSM state encoding
//           - GNT_IC/GNT_DC : requester ids used for grants and last_grant
//           - LINE_WORDS_DEFAULT : default beats per cache-line burst
//           - byte_off_w() : byte-offset width of a line (beat bits + 2)
// Revision: 1.0 - initial release
// ============================================================================
package cache_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IC_XFER = 2'd1,
        DC_XFER = 2'd2
    } arb_state_t;

    localparam logic GNT_IC = 1'b0;
    localparam logic GNT_DC = 1'b1;

    localparam int LINE_WORDS_DEFAULT = 4;

    // Number of low address bits that select a byte within a line
    // (word index within the line plus the 2-bit byte-in-word offset).
    function automatic int byte_off_w(input int line_words);
        return $clog2(line_words) + 2;
    endfunction

endpackage
`default_nettype wire

// File: rtl/arb_rr2.sv
`default_nettype none
// ============================================================================
// Module  : arb_rr2
// Purpose : Two-way round-robin picker between the I-cache and D-cache.
//           A lone request wins outright; when both request, the side that
//           did not win last time is chosen.
// Ports   : req_ic, req_dc  - request inputs
//           last_grant      - id of the previous burst owner (GNT_IC/GNT_DC)
//           winner          - chosen id (GNT_IC/GNT_DC), meaningful when valid
//           valid           - at least one request present
// Revision: 1.0 - initial release
// ============================================================================
module arb_rr2
    import cache_pkg::*;
(
    input  logic req_ic,
    input  logic req_dc,
    input  logic last_grant,
    output logic winner,
    output logic valid
);

    always_comb begin
        valid  = req_ic | req_dc;
        winner = GNT_IC;
        if (req_ic && req_dc) begin
            winner = (last_grant == GNT_IC) ? GNT_DC : GNT_IC;
        end else if (req_dc) begin
            winner = GNT_DC;
        end
    end

endmodule
`default_nettype wire

// File: rtl/cache_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : cache_mem_arbiter
// Purpose : Shares one external memory port between the I-cache refill path
//           and the D-cache refill/write-back path. A granted requester gets a
//           LINE_WORDS-beat burst issued as single-word req/ack handshakes;
//           read beats are passed straight through, and the waiting outputs
//           stall the F / M pipeline registers until the burst is done.
// Ports   : clk, rst (sync, active-high)
//           ic_req/ic_addr -> ic_rvalid/ic_rdata/ic_done/ic_waiting
//           dc_req/dc_we/dc_addr/dc_wdata -> dc_beat/dc_rvalid/dc_rdata/
//                                            dc_done/dc_waiting
//           mem_req/mem_we/mem_addr/mem_wdata <- mem_ack/mem_rdata
// Options : ARB_STATS_EN - adds saturating 32-bit counters stat_ic_bursts,
//           stat_dc_bursts, stat_conflicts and stat_mem_wait.
// Revision: 1.0 - initial release
// ============================================================================
module cache_mem_arbiter
    import cache_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int LINE_WORDS = LINE_WORDS_DEFAULT
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          ic_req,
    input  logic [ADDR_W-1:0]             ic_addr,
    output logic                          ic_rvalid,
    output logic [DATA_W-1:0]             ic_rdata,
    output logic                          ic_done,
    output logic                          ic_waiting,
    input  logic                          dc_req,
    input  logic                          dc_we,
    input  logic [ADDR_W-1:0]             dc_addr,
    input  logic [DATA_W-1:0]             dc_wdata,
    output logic [$clog2(LINE_WORDS)-1:0] dc_beat,
    output logic                          dc_rvalid,
    output logic [DATA_W-1:0]             dc_rdata,
    output logic                          dc_done,
    output logic                          dc_waiting,
    output logic                          mem_req,
    output logic                          mem_we,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic [DATA_W-1:0]             mem_wdata,
    input  logic                          mem_ack,
    input  logic [DATA_W-1:0]             mem_rdata
`ifdef ARB_STATS_EN
    ,
    output logic [31:0]                   stat_ic_bursts,
    output logic [31:0]                   stat_dc_bursts,
    output logic [31:0]                   stat_conflicts,
    output logic [31:0]                   stat_mem_wait
`endif
);

    localparam int BEAT_W = $clog2(LINE_WORDS);
    localparam int BOFF_W = byte_off_w(LINE_WORDS);

    arb_state_t          r_state;
    arb_state_t          w_state_nxt;
    logic [BEAT_W-1:0]   r_beat;
    logic [ADDR_W-1:0]   r_base;
    logic                r_we;
    logic                r_last_grant;

    logic                w_win;
    logic                w_win_valid;
    logic                w_grant;
    logic                w_burst_end;
    logic                w_ic_xfer;
    logic                w_dc_xfer;
    logic                w_xfer;
    logic                w_last_beat;
    logic [ADDR_W-1:0]   w_req_addr;
    logic [ADDR_W-1:0]   w_offset;
    logic                w_unused_low_bits;

    arb_rr2 u_rr (
        .req_ic     (ic_req),
        .req_dc     (dc_req),
        .last_grant (r_last_grant),
        .winner     (w_win),
        .valid      (w_win_valid)
    );

    assign w_ic_xfer   = (r_state == IC_XFER);
    assign w_dc_xfer   = (r_state == DC_XFER);
    assign w_xfer      = w_ic_xfer | w_dc_xfer;
    // LINE_WORDS is a power of two, so the final beat is the all-ones count.
    assign w_last_beat = &r_beat;

    // The line base keeps only the bits above the in-line byte offset.
    assign w_req_addr        = (w_win == GNT_DC) ? dc_addr : ic_addr;
    assign w_unused_low_bits = ^{ic_addr[BOFF_W-1:0], dc_addr[BOFF_W-1:0]};

    // ------------------------------------------------------------------
    // FSM: state register and next-state logic
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_burst_end = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_win_valid) begin
                    w_grant     = 1'b1;
                    w_state_nxt = (w_win == GNT_DC) ? DC_XFER : IC_XFER;
                end
            end
            IC_XFER, DC_XFER: begin
                if (mem_ack && w_last_beat) begin
                    w_burst_end = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Burst context: line base, direction, beat counter, fairness history
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_beat       <= '0;
            r_base       <= '0;
            r_we         <= 1'b0;
            r_last_grant <= GNT_IC;
        end else begin
            if (w_grant) begin
                r_beat <= '0;
                r_we   <= (w_win == GNT_DC) & dc_we;
                r_base <= {w_req_addr[ADDR_W-1:BOFF_W], {BOFF_W{1'b0}}};
            end else if (w_xfer && mem_ack) begin
                r_beat <= r_beat + 1'b1;
            end
            if (w_burst_end) begin
                r_last_grant <= w_ic_xfer ? GNT_IC : GNT_DC;
            end
        end
    end

    // ------------------------------------------------------------------
    // Memory side
    // ------------------------------------------------------------------
    assign w_offset  = {{(ADDR_W-BOFF_W){1'b0}}, r_beat, 2'b00};
    assign mem_req   = w_xfer;
    assign mem_addr  = w_xfer ? (r_base + w_offset) : '0;
    assign mem_we    = w_dc_xfer & r_we;
    assign mem_wdata = w_dc_xfer ? dc_wdata : '0;

    // ------------------------------------------------------------------
    // Requester side
    // ------------------------------------------------------------------
    assign ic_rvalid = w_ic_xfer & mem_ack;
    assign ic_rdata  = ic_rvalid ? mem_rdata : '0;
    assign ic_done   = w_ic_xfer & mem_ack & w_last_beat;

    assign dc_beat   = w_dc_xfer ? r_beat : '0;
    assign dc_rvalid = w_dc_xfer & mem_ack & ~r_we;
    assign dc_rdata  = dc_rvalid ? mem_rdata : '0;
    assign dc_done   = w_dc_xfer & mem_ack & w_last_beat;

    // Stall from the request cycle up to (not including) the done cycle;
    // held low while in reset so every output reads 0 during reset.
    assign ic_waiting = ic_req & ~ic_done & ~rst;
    assign dc_waiting = dc_req & ~dc_done & ~rst;

`ifdef ARB_STATS_EN
    logic [31:0] r_stat_ic;
    logic [31:0] r_stat_dc;
    logic [31:0] r_stat_conf;
    logic [31:0] r_stat_wait;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : (v + 32'd1);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stat_ic   <= '0;
            r_stat_dc   <= '0;
            r_stat_conf <= '0;
            r_stat_wait <= '0;
        end else begin
            if (ic_done) begin
                r_stat_ic <= sat_inc(r_stat_ic);
            end
            if (dc_done) begin
                r_stat_dc <= sat_inc(r_stat_dc);
            end
            if ((r_state == IDLE) && ic_req && dc_req) begin
                r_stat_conf <= sat_inc(r_stat_conf);
            end
            if (mem_req && !mem_ack) begin
                r_stat_wait <= sat_inc(r_stat_wait);
            end
        end
    end

    assign stat_ic_bursts = r_stat_ic;
    assign stat_dc_bursts = r_stat_dc;
    assign stat_conflicts = r_stat_conf;
    assign stat_mem_wait  = r_stat_wait;
`endif

endmodule
`default_nettype wire
